// File: rtl/tdm_demux_1to4.sv
// rtl/tdm_demux_1to4.sv - 1-to-4 TDM demultiplexer with frame-synchronised slot counter
// Optional: define TDM_DEMUX_ERR_EN to resync and pulse frame_err on a mid-frame frame_start.
module tdm_demux_1to4 #(
  parameter int WIDTH = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [WIDTH-1:0]   din,
  input  logic               din_valid,
  input  logic               frame_start,
  output logic [4*WIDTH-1:0] data_out,
  output logic               out_valid,
  output logic [1:0]         slot,
  output logic               frame_err
);

  typedef enum logic {HUNT, COLLECT} state_t;

  state_t           state;
  logic [WIDTH-1:0] ch0, ch1, ch2;

  // Slot 3 is never stored: it goes straight from din into data_out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= HUNT;
      slot      <= 2'd0;
      ch0       <= '0;
      ch1       <= '0;
      ch2       <= '0;
      data_out  <= '0;
      out_valid <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        HUNT: begin
          if (din_valid && frame_start) begin
            ch0   <= din;
            slot  <= 2'd1;
            state <= COLLECT;
          end
        end
        COLLECT: begin
          if (din_valid) begin
`ifdef TDM_DEMUX_ERR_EN
            if (frame_start && slot != 2'd0) begin
              ch0       <= din;
              slot      <= 2'd1;
              frame_err <= 1'b1;
            end else begin
              case (slot)
                2'd0: ch0 <= din;
                2'd1: ch1 <= din;
                2'd2: ch2 <= din;
                default: begin
                  data_out  <= {din, ch2, ch1, ch0};
                  out_valid <= 1'b1;
                end
              endcase
              slot <= slot + 2'd1;
            end
`else
            case (slot)
              2'd0: ch0 <= din;
              2'd1: ch1 <= din;
              2'd2: ch2 <= din;
              default: begin
                data_out  <= {din, ch2, ch1, ch0};
                out_valid <= 1'b1;
              end
            endcase
            slot <= slot + 2'd1;
`endif
          end
        end
        default: state <= HUNT;
      endcase
    end
  end

endmodule

// File: tb/tb_tdm_demux_1to4.sv
// tb/tb_tdm_demux_1to4.sv - self-checking bench for tdm_demux_1to4
module tb_tdm_demux_1to4;
  localparam int W = 1;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [W-1:0]   din;
  logic           din_valid;
  logic           frame_start;
  logic [4*W-1:0] data_out;
  logic           out_valid;
  logic [1:0]     slot;
  logic           frame_err;

  tdm_demux_1to4 #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid),
    .frame_start(frame_start), .data_out(data_out), .out_valid(out_valid),
    .slot(slot), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: a frame is just a growing list of samples.
  logic [W-1:0]   mq[$];
  bit             m_hunt = 1;
  logic [4*W-1:0] m_data = '0;
  bit             m_ov = 0;
  bit             m_err = 0;
`ifdef TDM_DEMUX_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  task automatic model_reset();
    mq.delete();
    m_hunt = 1; m_data = '0; m_ov = 0; m_err = 0;
  endtask

  task automatic model_step(input bit v, input bit fs, input logic [W-1:0] d);
    m_ov = 0; m_err = 0;
    if (v) begin
      if (m_hunt) begin
        if (fs) begin mq.delete(); mq.push_back(d); m_hunt = 0; end
      end else if (ERR_EN && fs && mq.size() != 0) begin
        m_err = 1; mq.delete(); mq.push_back(d);
      end else begin
        mq.push_back(d);
        if (mq.size() == 4) begin
          m_data = {mq[3], mq[2], mq[1], mq[0]};
          m_ov = 1;
          mq.delete();
        end
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".data_out"}, 32'(data_out), 32'(m_data));
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(m_ov));
    chk({tag, ".slot"}, 32'(slot), m_hunt ? 32'd0 : 32'(mq.size()));
    chk({tag, ".frame_err"}, 32'(frame_err), 32'(m_err));
  endtask

  // Drive at posedge+1, let the edge happen, sample at the next posedge+1.
  task automatic cyc(input bit v, input bit fs, input logic [W-1:0] d);
    din_valid = v; frame_start = fs; din = d;
    @(posedge clk);
    model_step(v, fs, d);
    #1;
    din_valid = 0; frame_start = 0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    @(posedge clk); #1;
    rst_n = 1;
    model_reset();
  endtask

  typedef struct {
    bit         v;
    bit         fs;
    logic [W-1:0] d;
    logic [3:0] exp_data;
    bit         exp_ov;
    logic [1:0] exp_slot;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input bit v, input bit fs, input logic [W-1:0] d,
                     input logic [3:0] ed, input bit eov, input logic [1:0] es);
    vec_t t;
    t.v = v; t.fs = fs; t.d = d; t.exp_data = ed; t.exp_ov = eov; t.exp_slot = es;
    vecs.push_back(t);
  endtask

  initial begin
    rst_n = 0; din = '0; din_valid = 0; frame_start = 0;
    @(posedge clk); #1;
    chk("reset.data_out", 32'(data_out), 32'd0);
    chk("reset.out_valid", 32'(out_valid), 32'd0);
    chk("reset.slot", 32'(slot), 32'd0);
    chk("reset.frame_err", 32'(frame_err), 32'd0);
    rst_n = 1;
    model_reset();

    // HUNT: samples without frame_start are ignored
    for (int i = 0; i < 4; i++) add(1, 0, 1'b1, 4'b0000, 0, 2'd0);
    // frame 0,1,0,1
    add(1, 1, 1'b0, 4'b0000, 0, 2'd1);
    add(1, 0, 1'b1, 4'b0000, 0, 2'd2);
    add(1, 0, 1'b0, 4'b0000, 0, 2'd3);
    add(1, 0, 1'b1, 4'b1010, 1, 2'd0);
    add(0, 0, 1'b0, 4'b1010, 0, 2'd0);
    // frame 0,0,1,1 with 3-cycle gaps; no frame_start needed
    add(1, 0, 1'b0, 4'b1010, 0, 2'd1);
    for (int i = 0; i < 3; i++) add(0, 0, 1'b1, 4'b1010, 0, 2'd1);
    add(1, 0, 1'b0, 4'b1010, 0, 2'd2);
    for (int i = 0; i < 3; i++) add(0, 1, 1'b1, 4'b1010, 0, 2'd2);
    add(1, 0, 1'b1, 4'b1010, 0, 2'd3);
    for (int i = 0; i < 3; i++) add(0, 0, 1'b0, 4'b1010, 0, 2'd3);
    add(1, 0, 1'b1, 4'b1100, 1, 2'd0);
    // back-to-back 1,0,1,0: pulse exactly 4 cycles later
    add(1, 0, 1'b1, 4'b1100, 0, 2'd1);
    add(1, 0, 1'b0, 4'b1100, 0, 2'd2);
    add(1, 0, 1'b1, 4'b1100, 0, 2'd3);
    add(1, 0, 1'b0, 4'b0101, 1, 2'd0);

    foreach (vecs[i]) begin
      cyc(vecs[i].v, vecs[i].fs, vecs[i].d);
      chk($sformatf("vec%0d.data_out", i), 32'(data_out), 32'(vecs[i].exp_data));
      chk($sformatf("vec%0d.out_valid", i), 32'(out_valid), 32'(vecs[i].exp_ov));
      chk($sformatf("vec%0d.slot", i), 32'(slot), 32'(vecs[i].exp_slot));
      chk($sformatf("vec%0d.frame_err", i), 32'(frame_err), 32'd0);
    end

    // Mid-frame frame_start: fs+1, 1, fs+0, 0, 1, 1
    begin
      int errs = 0;
      do_reset();
      cyc(1, 1, 1'b1); errs += frame_err;
      cyc(1, 0, 1'b1); errs += frame_err;
      cyc(1, 1, 1'b0); errs += frame_err; chk_model("resync.fs");
      cyc(1, 0, 1'b0); errs += frame_err; chk_model("resync.s1");
      cyc(1, 0, 1'b1); errs += frame_err; chk_model("resync.s2");
      cyc(1, 0, 1'b1); errs += frame_err; chk_model("resync.s3");
`ifdef TDM_DEMUX_ERR_EN
      chk("resync.err_count", 32'(errs), 32'd1);
      chk("resync.data_out", 32'(data_out), 32'b1100);
      chk("resync.out_valid", 32'(out_valid), 32'd1);
`else
      chk("resync.err_count", 32'(errs), 32'd0);
      chk("resync.data_out", 32'(data_out), 32'b0011);
      chk("resync.slot", 32'(slot), 32'd2);
`endif
    end

    // Asynchronous reset after two samples of a frame
    cyc(1, 1, 1'b1);
    cyc(1, 0, 1'b1);
    rst_n = 0;
    #1;
    chk("async_rst.data_out", 32'(data_out), 32'd0);
    chk("async_rst.out_valid", 32'(out_valid), 32'd0);
    chk("async_rst.slot", 32'(slot), 32'd0);
    chk("async_rst.frame_err", 32'(frame_err), 32'd0);
    @(posedge clk); #1;
    rst_n = 1;
    model_reset();
    cyc(1, 0, 1'b1); chk_model("post_rst.hunt");
    cyc(1, 1, 1'b1);
    cyc(1, 0, 1'b0);
    cyc(1, 0, 1'b0);
    cyc(1, 0, 1'b1);
    chk("post_rst.data_out", 32'(data_out), 32'b1001);
    chk("post_rst.out_valid", 32'(out_valid), 32'd1);

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      bit v, fs;
      v  = ($urandom_range(0, 9) < 7);
      fs = ($urandom_range(0, 19) == 0) || (m_hunt && $urandom_range(0, 3) == 0);
      cyc(v, fs, W'($urandom));
      chk_model($sformatf("rand%0d", i));
      if (out_valid && frame_err) chk("rand.pulse_overlap", 32'd1, 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
